// File: rtl/retospect_cfg_loader.sv
// Configuration scan-chain sequencer: serialises host bytes LSB-first onto the CNB chain while
// capturing the bits that fall out of the far end, or recirculates them for a non-destructive read.
module retospect_cfg_loader #(
  parameter int unsigned CELLS         = 1,
  parameter int unsigned BITS_PER_CELL = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       mode,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       config_en,
  output logic       bs_in,
  input  logic       bs_out,
  output logic       busy,
  output logic       done
);

  localparam int unsigned ChainLen = CELLS * BITS_PER_CELL;
  localparam int unsigned NBytes   = (ChainLen + 7) / 8;
  localparam int unsigned RBits    = ChainLen - 8 * (NBytes - 1);
  localparam int unsigned CntW     = $clog2(ChainLen + 1);

  typedef enum logic [2:0] {StIdle, StFetch, StShift, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [7:0]        cap_q, cap_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [CntW-1:0]   bitcnt_q, bitcnt_d;
  logic [CntW-1:0]   bytecnt_q, bytecnt_d;

  logic last_byte, last_bit, stall, shift_en;

  always_comb begin
    last_byte = (bytecnt_q == CntW'(NBytes - 1));
    last_bit  = last_byte ? (bitcnt_q == CntW'(RBits - 1)) : (bitcnt_q == CntW'(7));
    // Hold the chain rather than overwrite a captured byte the host has not taken yet.
    stall     = last_bit && out_valid_q && !out_ready;
    shift_en  = (state_q == StShift) && !stall;
  end

  assign config_en = shift_en;
  assign bs_in     = (state_q == StShift) ? (mode_q ? bs_out : shreg_q[0]) : 1'b0;
  assign in_ready  = (state_q == StFetch);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    shreg_d     = shreg_q;
    cap_d       = cap_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    bitcnt_d    = bitcnt_q;
    bytecnt_d   = bytecnt_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          mode_d    = mode;
          bitcnt_d  = '0;
          bytecnt_d = '0;
          cap_d     = '0;
          state_d   = mode ? StShift : StFetch;
        end
      end
      StFetch: begin
        if (in_valid) begin
          shreg_d = in_data;
          state_d = StShift;
        end
      end
      StShift: begin
        if (shift_en) begin
          shreg_d                = {1'b0, shreg_q[7:1]};
          cap_d[bitcnt_q[2:0]]   = bs_out;
          if (last_bit) begin
            out_data_d  = cap_d;
            out_valid_d = 1'b1;
            cap_d       = '0;
            bitcnt_d    = '0;
            bytecnt_d   = bytecnt_q + CntW'(1);
            if (last_byte)   state_d = StDrain;
            else if (mode_q) state_d = StShift;
            else             state_d = StFetch;
          end else begin
            bitcnt_d = bitcnt_q + CntW'(1);
          end
        end
      end
      StDrain: begin
        if (!out_valid_q) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      shreg_q     <= '0;
      cap_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      bitcnt_q    <= '0;
      bytecnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      shreg_q     <= shreg_d;
      cap_q       <= cap_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      bitcnt_q    <= bitcnt_d;
      bytecnt_q   <= bytecnt_d;
    end
  end

endmodule

// File: tb/tb_retospect_cfg_loader.sv
// Directed bench: two loaders (1-cell and 2-cell chains) each driving a behavioural scan chain.
module tb_retospect_cfg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, rst2, start, mode, in_valid, out_ready, sel;
  logic [7:0] in_data;

  logic       in_ready1, out_valid1, cfg1, bs_in1, bs_out1, busy1, done1;
  logic [7:0] out_data1;
  logic       in_ready2, out_valid2, cfg2, bs_in2, bs_out2, busy2, done2;
  logic [7:0] out_data2;

  retospect_cfg_loader #(.CELLS(1), .BITS_PER_CELL(19)) dut1 (
    .clk(clk), .reset(rst1), .start(start & ~sel), .mode(mode),
    .in_data(in_data), .in_valid(in_valid & ~sel), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .config_en(cfg1), .bs_in(bs_in1), .bs_out(bs_out1), .busy(busy1), .done(done1)
  );

  retospect_cfg_loader #(.CELLS(2), .BITS_PER_CELL(19)) dut2 (
    .clk(clk), .reset(rst2), .start(start & sel), .mode(mode),
    .in_data(in_data), .in_valid(in_valid & sel), .in_ready(in_ready2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
    .config_en(cfg2), .bs_in(bs_in2), .bs_out(bs_out2), .busy(busy2), .done(done2)
  );

  // Chain models: bit enters at [0], leaves from the top.
  logic [18:0] chain1 = '0;
  logic [37:0] chain2 = '0;
  always @(posedge clk) if (cfg1) chain1 <= {chain1[17:0], bs_in1};
  always @(posedge clk) if (cfg2) chain2 <= {chain2[36:0], bs_in2};
  assign bs_out1 = chain1[18];
  assign bs_out2 = chain2[37];

  logic       in_ready_s, out_valid_s, cfg_s, done_s;
  logic [7:0] out_data_s;
  assign in_ready_s  = sel ? in_ready2  : in_ready1;
  assign out_valid_s = sel ? out_valid2 : out_valid1;
  assign cfg_s       = sel ? cfg2       : cfg1;
  assign done_s      = sel ? done2      : done1;
  assign out_data_s  = sel ? out_data2  : out_data1;

  int         cfg_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] outq[$];
  always @(negedge clk) begin
    #1;
    if (cfg_s) cfg_cnt++;
    if (done_s) done_cnt++;
    if (out_valid_s && out_ready) outq.push_back(out_data_s);
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input bit s, input bit m, input logic [39:0] vin, input logic [39:0] vexp,
                      input int n, input int gap_at, input int gap_len, input bit stall_test);
    int base_cfg, base_done, base_q, to, clen;
    sel       = s;
    clen      = s ? 38 : 19;
    base_cfg  = cfg_cnt;
    base_done = done_cnt;
    base_q    = outq.size();
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (!m) begin
      for (int i = 0; i < n; i++) begin
        to = 0;
        while (!in_ready_s && to < 100) begin
          @(negedge clk);
          to++;
        end
        chk("in_ready_wait", 64'(to < 100), 1);
        if (i == gap_at) begin
          for (int g = 0; g < gap_len; g++) begin
            chk("gap_cfg_en", 64'(cfg_s), 0);
            chk("gap_in_ready", 64'(in_ready_s), 1);
            @(negedge clk);
          end
        end
        in_data  = vin[8*i +: 8];
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    if (stall_test) begin
      to = 0;
      while (!((cfg_cnt - base_cfg) == 15 && !cfg_s) && to < 300) begin
        @(negedge clk);
        #2;
        to++;
      end
      chk("stall_reached", 64'(to < 300), 1);
      chk("stall_cfg_count", 64'(cfg_cnt - base_cfg), 15);
      repeat (4) begin
        @(negedge clk);
        #2;
        chk("stall_cfg_en", 64'(cfg_s), 0);
        chk("stall_out_valid", 64'(out_valid_s), 1);
        chk("stall_out_data", 64'(out_data_s), 64'(vexp[7:0]));
      end
      @(negedge clk);
      out_ready = 1'b1;
    end
    to = 0;
    while (done_cnt == base_done && to < 500) begin
      @(negedge clk);
      #2;
      to++;
    end
    chk("done_seen", 64'(to < 500), 1);
    repeat (3) @(negedge clk);
    #2;
    chk("done_pulses", 64'(done_cnt - base_done), 1);
    chk("cfg_en_cycles", 64'(cfg_cnt - base_cfg), 64'(clen));
    chk("out_bytes", 64'(outq.size() - base_q), 64'(n));
    chk("busy_after", 64'(s ? busy2 : busy1), 0);
    for (int i = 0; i < n; i++) begin
      if (base_q + i < outq.size())
        chk($sformatf("out_byte%0d", i), 64'(outq[base_q + i]), 64'(vexp[8*i +: 8]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [18:0] snap1;
  int          to6, base6;

  initial begin
    sel = 1'b0; start = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    rst1 = 1'b1; rst2 = 1'b1;
    repeat (3) @(negedge clk);
    rst1 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    #2;
    chk("rst_in_ready", 64'(in_ready1), 0);
    chk("rst_out_valid", 64'(out_valid1), 0);
    chk("rst_config_en", 64'(cfg1), 0);
    chk("rst_bs_in", 64'(bs_in1), 0);
    chk("rst_busy", 64'(busy1), 0);
    chk("rst_done", 64'(done1), 0);
    chk("rst_busy2", 64'(busy2), 0);

    // Load into an all-zero chain, then read back twice without disturbing it.
    xfer(0, 0, 40'h00_00_FD_3C_A5, 40'h00_00_00_00_00, 3, -1, 0, 0);
    snap1 = chain1;
    xfer(0, 1, 40'h0, 40'h00_00_05_3C_A5, 3, -1, 0, 0);
    chk("chain_kept_1", 64'(chain1), 64'(snap1));
    xfer(0, 1, 40'h0, 40'h00_00_05_3C_A5, 3, -1, 0, 0);
    chk("chain_kept_2", 64'(chain1), 64'(snap1));

    // Readback with the host refusing output for a while.
    out_ready = 1'b0;
    xfer(0, 1, 40'h0, 40'h00_00_05_3C_A5, 3, -1, 0, 1);
    chk("chain_kept_3", 64'(chain1), 64'(snap1));

    // Load with a gap before the second byte, then read the new contents.
    xfer(0, 0, 40'h00_00_56_34_12, 40'h00_00_05_3C_A5, 3, 1, 5, 0);
    xfer(0, 1, 40'h0, 40'h00_00_06_34_12, 3, -1, 0, 0);

    // Two-cell chain, 38 bits, short last byte of 6 bits.
    xfer(1, 0, 40'h3F_44_33_22_11, 40'h00_00_00_00_00, 5, -1, 0, 0);
    xfer(1, 1, 40'h0, 40'h3F_44_33_22_11, 5, -1, 0, 0);

    // Reset after 10 shifts of a load of 77,88,99.
    sel   = 1'b0;
    base6 = cfg_cnt;
    @(negedge clk);
    mode  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      to6 = 0;
      while (!in_ready1 && to6 < 100) begin
        @(negedge clk);
        to6++;
      end
      in_data  = (i == 0) ? 8'h77 : 8'h88;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
    end
    to6 = 0;
    while ((cfg_cnt - base6) != 10 && to6 < 100) begin
      @(negedge clk);
      #2;
      to6++;
    end
    chk("t6_reached_10", 64'(cfg_cnt - base6), 10);
    rst1 = 1'b1;
    @(negedge clk);
    #2;
    chk("t6_busy", 64'(busy1), 0);
    chk("t6_config_en", 64'(cfg1), 0);
    chk("t6_out_valid", 64'(out_valid1), 0);
    chk("t6_in_ready", 64'(in_ready1), 0);
    @(negedge clk);
    rst1 = 1'b0;
    // Chain now holds old bits 10..18 of (12,34,06) followed by 10 bits of 77,88.
    xfer(0, 0, 40'h0, 40'h00_00_00_EF_8D, 3, -1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
